// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM states and flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_0000 = 4'b0000;
    localparam logic [3:0] OP_0001 = 4'b0001;
    localparam logic [3:0] OP_0010 = 4'b0010;
    localparam logic [3:0] OP_0011 = 4'b0011;
    localparam logic [3:0] OP_0100 = 4'b0100;
    localparam logic [3:0] OP_0101 = 4'b0101;
    localparam logic [3:0] OP_0110 = 4'b0110;
    localparam logic [3:0] OP_0111 = 4'b0111;
    localparam logic [3:0] OP_1000 = 4'b1000;
    localparam logic [3:0] OP_1001 = 4'b1001;
    localparam logic [3:0] OP_MAX  = OP_1001;

    localparam int FLAG_CARRY = 3;
    localparam int FLAG_S     = 2;
    localparam int FLAG_Z     = 1;
    localparam int FLAG_P     = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Unary opcodes ignore B, so the issue stage presents B = 0 for them.
    function automatic logic is_unary(input logic [3:0] op);
        return (op == OP_0110) || (op == OP_1000) || (op == OP_1001);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x W register file: two combinational read ports, a debug peek port and one
// synchronous write port, cleared by asynchronous reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int  NREG = 4,
    parameter int  W    = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [W-1:0]  o_rdata1,
    output logic [W-1:0]  o_rdata2,
    output logic [W-1:0]  o_dbg_data
);

    logic [W-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1   = r_mem[i_raddr1];
    assign o_rdata2   = r_mem[i_raddr2];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Serial issue stage for an external combinational ALU: latches one instruction,
// drives the ALU for one EXEC cycle, writes back and presents the result.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int  NREG = 4,
    parameter int  W    = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    // Both ports: a transfer happens on a rising edge where valid && ready;
    // valid and its payload must not change until that transfer.
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_ld,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          in_use_imm,
    input  logic [W-1:0]  in_imm,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_carry,
    input  logic          alu_s,
    input  logic          alu_z,
    input  logic          alu_p,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic [3:0]    out_flags,
    output logic          out_err,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data,
    output logic [1:0]    dbg_state
);

    state_t        r_state;
    logic [AW-1:0] r_rd;
    logic [W-1:0]  r_alu_a;
    logic [W-1:0]  r_alu_b;
    logic [3:0]    r_alu_op;
    logic [W-1:0]  r_out_result;
    logic [3:0]    r_out_flags;
    logic          r_out_err;

    logic          w_accept;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [W-1:0]  w_wdata;
    logic [W-1:0]  w_rs1_data;
    logic [W-1:0]  w_rs2_data;

    assign w_accept = in_valid && (r_state == IDLE);

    // Loads write at the accept edge; ALU results write at the end of EXEC.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_rd;
        w_wdata = alu_result;
        if (w_accept && in_ld) begin
            w_we    = 1'b1;
            w_waddr = in_rd;
            w_wdata = in_imm;
        end else if (r_state == EXEC) begin
            w_we = 1'b1;
        end
    end

    alu_regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_raddr1   (in_rs1),
        .i_raddr2   (in_rs2),
        .i_dbg_addr (dbg_addr),
        .o_rdata1   (w_rs1_data),
        .o_rdata2   (w_rs2_data),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rd         <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_out_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (in_ld) begin
                            r_out_result <= in_imm;
                            r_out_err    <= 1'b0;
                            r_state      <= WB;
                        end else if (is_illegal(in_op)) begin
                            r_out_err <= 1'b1;
                            r_state   <= WB;
                        end else begin
                            r_rd     <= in_rd;
                            r_alu_a  <= w_rs1_data;
                            r_alu_b  <= is_unary(in_op) ? '0 :
                                        (in_use_imm ? in_imm : w_rs2_data);
                            r_alu_op <= in_op;
                            r_state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_out_result             <= alu_result;
                    r_out_flags[FLAG_CARRY]  <= alu_carry;
                    r_out_flags[FLAG_S]      <= alu_s;
                    r_out_flags[FLAG_Z]      <= alu_z;
                    r_out_flags[FLAG_P]      <= alu_p;
                    r_out_err                <= 1'b0;
                    r_state                  <= WB;
                end
                WB: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == WB);
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;
    assign out_err    = r_out_err;
    assign dbg_state  = r_state;

endmodule
